// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM encodings and default constants for the UART transmitter
package uart_tx_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;
  localparam int DEF_BAUD_DIV   = 416;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_FIFO_AW    = 4;
  localparam logic IDLE_LVL     = 1'b1;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: register-array byte FIFO with registered full/empty flags
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int FIFO_AW    = DEF_FIFO_AW
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(FIFO_DEPTH);
  logic [7:0] mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] cnt, cnt_nxt;
  logic do_push, do_pop;
  // full gates pushes on the pre-pop occupancy, so a push during a pop-while-full is dropped
  always_comb begin
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    cnt_nxt = cnt + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(do_pop);
    rdata   = mem[rd_ptr];
  end
  // storage array; contents need no reset since the flags guard every read
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
  // pointers wrap naturally at the power-of-two depth; flags track the next count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr + FIFO_AW'(do_push);
      rd_ptr <= rd_ptr + FIFO_AW'(do_pop);
      cnt    <= cnt_nxt;
      full   <= cnt_nxt == DEPTH_C;
      empty  <= cnt_nxt == '0;
    end
endmodule

// File: rtl/uart_tx_ser.sv
// uart_tx_ser: buffered 8N1 UART transmitter fed by a byte strobe interface
module uart_tx_ser
  import uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int FIFO_AW    = DEF_FIFO_AW,
  parameter int BAUD_DIV   = DEF_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] send_char,
  input  logic       send_en,
  output logic       tx_fifo_full,
  output logic       tx_fifo_empty,
  output logic       tx_busy,
  output logic       uart_tx
);
  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  tx_state_t state, state_nxt;
  logic [11:0] baud_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift, shift_nxt, head;
  logic pop, baud_done, tx_d;
  uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (send_en),
    .pop   (pop),
    .wdata (send_char),
    .rdata (head),
    .full  (tx_fifo_full),
    .empty (tx_fifo_empty)
  );
  assign baud_done = baud_cnt == BAUD_LAST;
  assign tx_busy   = state != IDLE;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next-state: each non-idle state lasts BAUD_DIV cycles, DATA repeats for 8 bits
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = tx_fifo_empty ? IDLE : START;
      START: state_nxt = baud_done ? DATA : START;
      DATA:  state_nxt = (baud_done && bit_idx == 3'd7) ? STOP : DATA;
      STOP:  state_nxt = baud_done ? IDLE : STOP;
    endcase
  end
  // outputs: the line level is computed from the next state so uart_tx can be registered
  always_comb begin
    pop       = state == IDLE && !tx_fifo_empty;
    shift_nxt = pop ? head : (state == DATA && baud_done) ? {1'b0, shift[7:1]} : shift;
    tx_d      = state_nxt == START ? 1'b0 : state_nxt == DATA ? shift_nxt[0] : IDLE_LVL;
  end
  // baud and bit counters, shift register and registered line driver
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      uart_tx  <= IDLE_LVL;
    end else begin
      baud_cnt <= (state == IDLE || baud_done) ? '0 : baud_cnt + 12'd1;
      bit_idx  <= state == IDLE ? 3'd0 : (state == DATA && baud_done) ? bit_idx + 3'd1 : bit_idx;
      shift    <= shift_nxt;
      uart_tx  <= tx_d;
    end
endmodule

// File: tb/tb_uart_tx_ser.sv
// tb_uart_tx_ser: directed self-checking bench for the buffered UART transmitter
module tb_uart_tx_ser;
  localparam int BD = 4;
  localparam int FD = 4;
  localparam int AW = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic send_en = 1'b0;
  logic [7:0] send_char = 8'h00;
  logic tx_fifo_full, tx_fifo_empty, tx_busy, uart_tx;
  int cyc = 0;
  int vectors = 0;
  int errors = 0;
  logic [7:0] rx_q[$];
  int rt_q[$];
  int ph = 0;
  int t0 = 0;
  logic [7:0] sh = 8'h00;

  uart_tx_ser #(.FIFO_DEPTH(FD), .FIFO_AW(AW), .BAUD_DIV(BD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .send_char     (send_char),
    .send_en       (send_en),
    .tx_fifo_full  (tx_fifo_full),
    .tx_fifo_empty (tx_fifo_empty),
    .tx_busy       (tx_busy),
    .uart_tx       (uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    send_char = b;
    send_en = 1'b1;
    tick();
    send_en = 1'b0;
  endtask

  task automatic clr();
    rx_q.delete();
    rt_q.delete();
  endtask

  // line receiver: samples mid-bit, records each byte and its first start-bit cycle
  always @(negedge clk) begin
    if (!rst_n) ph = 0;
    else if (ph == 0) begin
      if (uart_tx === 1'b0) begin
        ph = 1;
        t0 = cyc;
      end
    end else begin
      ph++;
      if (ph % 4 == 2) begin
        if (ph == 2) chk("start_bit", 32'(uart_tx), 32'd0);
        else if (ph < 38) sh = {uart_tx, sh[7:1]};
        else begin
          chk("stop_bit", 32'(uart_tx), 32'd1);
          rx_q.push_back(sh);
          rt_q.push_back(t0);
          ph = 0;
        end
      end
    end
  end

  initial begin
    int n, idx, g;
    logic e;
    logic [7:0] b;
    bit seen_full, seen_drain;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_tx", 32'(uart_tx), 32'd1);
      chk("idle_empty", 32'(tx_fifo_empty), 32'd1);
      chk("idle_full", 32'(tx_fifo_full), 32'd0);
      chk("idle_busy", 32'(tx_busy), 32'd0);
    end

    tick();
    n = cyc;
    b = 8'h41;
    wr(b);
    @(negedge clk);
    chk("single_empty_n1", 32'(tx_fifo_empty), 32'd0);
    chk("single_tx_n1", 32'(uart_tx), 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      idx = (i - 4) / 4;
      e = i < 4 ? 1'b0 : i < 36 ? b[idx[2:0]] : 1'b1;
      chk($sformatf("frame41_c%0d", i), 32'(uart_tx), 32'(e));
      if (i == 39) chk("single_busy_n41", 32'(tx_busy), 32'd1);
    end
    @(negedge clk);
    chk("single_busy_n42", 32'(tx_busy), 32'd0);
    chk("single_tx_n42", 32'(uart_tx), 32'd1);
    repeat (5) tick();
    chk("single_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() == 1) begin
      chk("single_byte", 32'(rx_q[0]), 32'h41);
      chk("single_start", 32'(rt_q[0]), 32'(n + 2));
    end
    clr();

    tick();
    n = cyc;
    for (int i = 0; i < 6; i++) begin
      send_char = 8'(8'h30 + i);
      send_en = 1'b1;
      if (i == 5) begin
        @(negedge clk);
        chk("overfill_full", 32'(tx_fifo_full), 32'd1);
      end
      tick();
    end
    send_en = 1'b0;
    @(negedge clk);
    chk("overfill_full_after", 32'(tx_fifo_full), 32'd1);
    repeat (260) tick();
    chk("overfill_count", 32'(rx_q.size()), 32'd5);
    if (rx_q.size() == 5) begin
      chk("overfill_start0", 32'(rt_q[0]), 32'(n + 2));
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("overfill_byte%0d", i), 32'(rx_q[i]), 32'(8'h30 + i));
        if (i > 0) chk($sformatf("overfill_gap%0d", i), 32'(rt_q[i] - rt_q[i-1]), 32'd41);
      end
    end
    clr();

    seen_full = 0;
    seen_drain = 0;
    idx = 0;
    g = 0;
    while (idx < 20 && g < 2000) begin
      if (!tx_fifo_full) begin
        if (seen_full) seen_drain = 1;
        send_char = 8'(idx);
        send_en = 1'b1;
        idx++;
      end else begin
        send_en = 1'b0;
        seen_full = 1;
      end
      tick();
      g++;
    end
    send_en = 1'b0;
    chk("stream_all_sent", 32'(idx), 32'd20);
    g = 0;
    while (rx_q.size() < 20 && g < 1500) begin
      tick();
      g++;
    end
    repeat (10) tick();
    chk("stream_count", 32'(rx_q.size()), 32'd20);
    chk("stream_full_seen", 32'(seen_full), 32'd1);
    chk("stream_full_cleared", 32'(seen_drain), 32'd1);
    chk("stream_end_empty", 32'(tx_fifo_empty), 32'd1);
    chk("stream_end_full", 32'(tx_fifo_full), 32'd0);
    if (rx_q.size() == 20)
      for (int i = 0; i < 20; i++) begin
        chk($sformatf("stream_byte%0d", i), 32'(rx_q[i]), 32'(i));
        if (i > 0) chk($sformatf("stream_gap%0d", i), 32'(rt_q[i] - rt_q[i-1]), 32'd41);
      end
    clr();

    tick();
    n = cyc;
    wr(8'hA1);
    repeat (9) tick();
    wr(8'hB2);
    repeat (31) tick();
    wr(8'hC3);
    @(negedge clk);
    chk("coinc_empty", 32'(tx_fifo_empty), 32'd0);
    chk("coinc_full", 32'(tx_fifo_full), 32'd0);
    chk("coinc_busy", 32'(tx_busy), 32'd1);
    repeat (130) tick();
    chk("coinc_count", 32'(rx_q.size()), 32'd3);
    if (rx_q.size() == 3) begin
      chk("coinc_b0", 32'(rx_q[0]), 32'hA1);
      chk("coinc_b1", 32'(rx_q[1]), 32'hB2);
      chk("coinc_b2", 32'(rx_q[2]), 32'hC3);
      chk("coinc_t0", 32'(rt_q[0]), 32'(n + 2));
      chk("coinc_t1", 32'(rt_q[1]), 32'(n + 43));
      chk("coinc_t2", 32'(rt_q[2]), 32'(n + 84));
    end
    chk("coinc_end_empty", 32'(tx_fifo_empty), 32'd1);
    clr();

    tick();
    wr(8'h55);
    wr(8'h66);
    wr(8'h77);
    repeat (16) tick();
    @(negedge clk);
    chk("abort_pre_tx", 32'(uart_tx), 32'd0);
    chk("abort_pre_busy", 32'(tx_busy), 32'd1);
    chk("abort_pre_empty", 32'(tx_fifo_empty), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_tx", 32'(uart_tx), 32'd1);
    chk("abort_empty", 32'(tx_fifo_empty), 32'd1);
    chk("abort_busy", 32'(tx_busy), 32'd0);
    chk("abort_full", 32'(tx_fifo_full), 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("post_abort_tx", 32'(uart_tx), 32'd1);
    end
    chk("post_abort_frames", 32'(rx_q.size()), 32'd0);
    chk("post_abort_empty", 32'(tx_fifo_empty), 32'd1);
    chk("post_abort_busy", 32'(tx_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
